// File: rtl/fb_scanout.sv
// Framebuffer scanout reader: walks a dpram read port in raster order and streams
// pixels with x/y, end-of-line and end-of-frame tags over valid/ready.
module fb_scanout #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned HEIGHT     = 4,
    parameter int unsigned ADDR_BITS  = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1,
    parameter int unsigned X_BITS     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned Y_BITS     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_BITS-1:0]  rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [X_BITS-1:0]     out_x,
    output logic [Y_BITS-1:0]     out_y,
    output logic                  out_eol,
    output logic                  out_eof
);

    localparam int unsigned          N        = WIDTH * HEIGHT;
    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(N - 1);
    localparam logic [X_BITS-1:0]    LastX    = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0]    LastY    = Y_BITS'(HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic                   a_valid_q, a_valid_d;   // address on rd_addr this cycle
    logic                   b_valid_q;              // rd_data valid this cycle
    logic [DATA_WIDTH-1:0]  fifo_mem_q [4];
    logic [1:0]             wr_ptr_q, rd_ptr_q;
    logic [2:0]             fifo_cnt_q, fifo_cnt_d;
    logic [X_BITS-1:0]      x_q, x_d;
    logic [Y_BITS-1:0]      y_q, y_d;
    logic [3:0]             occupancy;
    logic                   push, pop;

    // Every issued read owns a FIFO slot until it is popped, so the FIFO cannot overflow.
    assign occupancy = 4'(fifo_cnt_q) + 4'(a_valid_q) + 4'(b_valid_q);
    assign push      = b_valid_q;
    assign pop       = out_valid && out_ready;

    assign busy      = (state_q != StIdle);
    assign rd_addr   = rd_addr_q;
    assign out_valid = (fifo_cnt_q != 3'd0);
    assign out_data  = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_eol   = out_valid && (x_q == LastX);
    assign out_eof   = out_eol && (y_q == LastY);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        a_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rd_addr_d = '0;
                    a_valid_d = 1'b1;
                    state_d   = (N == 1) ? StDrain : StFetch;
                end
            end
            StFetch: begin
                if (occupancy < 4'd4) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    a_valid_d = 1'b1;
                    if (rd_addr_d == LastAddr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && out_eof) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
        x_d        = x_q;
        y_d        = y_q;
        if (pop) begin
            if (x_q == LastX) begin
                x_d = '0;
                y_d = (y_q == LastY) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= a_valid_q;
            fifo_cnt_q <= fifo_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= rd_data;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: cycle table for the first frame, scoreboard for all pixels,
// plus stall, restart, reset, back-to-back, random-ready and 1x1 sequences.
module tb_fb_scanout;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n, start, out_ready, busy, out_valid, out_eol, out_eof;
    logic [3:0] rd_addr;
    logic [7:0] rd_data, out_data;
    logic [1:0] out_x, out_y;

    logic       s_start, s_ready, s_busy, s_valid, s_eol, s_eof;
    logic [0:0] s_addr, s_x, s_y;
    logic [7:0] s_rd_data, s_data;

    always #5 clk = ~clk;

    fb_scanout #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_eol(out_eol), .out_eof(out_eof)
    );

    fb_scanout #(.DATA_WIDTH(8), .WIDTH(1), .HEIGHT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .rd_addr(s_addr),
        .rd_data(s_rd_data), .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
        .out_x(s_x), .out_y(s_y), .out_eol(s_eol), .out_eof(s_eof)
    );

    logic [7:0] ram [N];
    always @(posedge clk) rd_data <= ram[rd_addr];
    always @(posedge clk) s_rd_data <= 8'hA5 + {7'b0, s_addr};

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] x;
        logic [1:0] y;
        logic       eol;
        logic       eof;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frame_pix = 0;
    int   issued = 0;
    int   popped = 0;
    int   max_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard / monitor, sampled mid-cycle.
    logic prev_busy = 1'b0;
    logic [3:0] prev_addr = '0;
    logic stall_prev = 1'b0;
    pix_t prev_pix;
    always @(negedge clk) begin
        pix_t cur, e;
        cur = '{data: out_data, x: out_x, y: out_y, eol: out_eol, eof: out_eof};
        if (!rst_n) begin
            prev_busy  = 1'b0;
            stall_prev = 1'b0;
            issued     = 0;
            popped     = 0;
        end else begin
            if (busy && (!prev_busy || rd_addr != prev_addr)) issued++;
            if (issued - popped > max_out) max_out = issued - popped;
            if (stall_prev) chk("hold", {out_valid, cur}, {1'b1, prev_pix});
            if (out_valid && out_ready) begin
                popped++;
                frame_pix++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", {out_valid, cur}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {16'h0, cur}, {16'h0, e});
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_pix   = cur;
            prev_busy  = busy;
            prev_addr  = rd_addr;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            pix_t p;
            p = '{data: ram[i], x: 2'(i % W), y: 2'(i / W), eol: (i % W) == W - 1,
                  eof: i == N - 1};
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_idle(input bit rnd, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            next_cycle();
            start = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: timeout with %0d pending, required 0", exp_q.size());
        end
    endtask

    // Called in the cycle start is driven; checks first-pixel latency of 3 cycles.
    task automatic start_and_check(input string name);
        start = 1'b1;
        out_ready = 1'b1;
        push_frame();
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk({name, "_c1"}, {busy, rd_addr}, {1'b1, 4'd0});
        next_cycle();
        @(negedge clk);
        chk({name, "_c2"}, {31'h0, out_valid}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk({name, "_c3"}, {out_valid, out_data, out_x, out_y}, {1'b1, ram[0], 2'd0, 2'd0});
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic [19:0] exp;  // busy, rd_addr, valid, data, x, y, eol, eof
    } vec_t;
    vec_t tab[21];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 21; c++) begin
            int k;
            logic v;
            logic [3:0] a;
            k = c - 3;
            v = (c >= 3 && c <= 18);
            a = (c == 0) ? 4'd0 : (c <= 16 ? 4'(c - 1) : 4'd15);
            tab[c].start = (c == 0);
            tab[c].ready = 1'b1;
            tab[c].exp = {(c >= 1 && c <= 18), a, v, v ? 8'(8'h10 + k) : 8'h00,
                          v ? 2'(k % W) : 2'd0, v ? 2'(k / W) : 2'd0,
                          v && (k % W == W - 1), c == 18};
        end
        for (int i = 0; i < N; i++) ram[i] = 8'(8'h10 + i);

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", {busy, rd_addr, out_valid, out_data, out_x, out_y, out_eol, out_eof},
            32'h0);

        // Frame 1: full cycle table with ready held high.
        for (int c = 0; c < 21; c++) begin
            next_cycle();
            if (tab[c].start && !busy) push_frame();
            start = tab[c].start;
            out_ready = tab[c].ready;
            @(negedge clk);
            chk($sformatf("table_c%0d", c),
                {12'h0, busy, rd_addr, out_valid, out_data, out_x, out_y, out_eol, out_eof},
                {12'h0, tab[c].exp});
        end
        start = 1'b0;
        wait_idle(1'b0, 100);

        // Backpressure in cycles 5..12.
        frame_pix = 0; max_out = 0;
        for (int c = 0; c <= 12; c++) begin
            next_cycle();
            start = (c == 0);
            if (start) push_frame();
            out_ready = !(c >= 5 && c <= 12);
            @(negedge clk);
            if (c == 7) chk("stall_addr_c7", {28'h0, rd_addr}, 32'd5);
            if (c == 12) begin
                chk("stall_addr_c12", {28'h0, rd_addr}, 32'd5);
                chk("stall_data", {out_valid, out_data}, {1'b1, 8'h12});
            end
        end
        wait_idle(1'b0, 100);
        chk("stall_count", frame_pix, 16);
        chk("stall_occupancy", {31'h0, max_out <= 4}, 32'h1);

        // Start pulsed mid-frame must be ignored.
        frame_pix = 0;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            start = (c == 0 || c == 8);
            if (c == 0) push_frame();
            @(negedge clk);
        end
        wait_idle(1'b0, 100);
        chk("restart_ignored_count", frame_pix, 16);

        // Reset in cycle 8 of a frame, then restart.
        for (int c = 0; c <= 7; c++) begin
            next_cycle();
            start = (c == 0);
            if (c == 0) push_frame();
        end
        next_cycle();
        rst_n = 1'b0;
        exp_q.delete();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midframe_reset", {busy, rd_addr, out_valid, out_data, out_x, out_y, out_eol, out_eof},
            32'h0);
        next_cycle();
        start_and_check("after_reset");
        wait_idle(1'b0, 100);

        // Back-to-back frames: second start in the cycle busy drops.
        frame_pix = 0;
        next_cycle();
        start_and_check("b2b_first");
        begin
            int n;
            n = 0;
            next_cycle();
            while (busy && n < 100) begin
                next_cycle();
                n++;
            end
            chk("b2b_busy_drop", {31'h0, busy}, 32'h0);
        end
        start_and_check("b2b_second");
        wait_idle(1'b0, 100);
        chk("b2b_count", frame_pix, 32);

        // Random ready, 3 frames with fresh contents.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) ram[i] = 8'($urandom);
            frame_pix = 0; max_out = 0;
            next_cycle();
            start = 1'b1;
            push_frame();
            wait_idle(1'b1, 500);
            chk($sformatf("rand_count_f%0d", f), frame_pix, 16);
            chk($sformatf("rand_occupancy_f%0d", f), {31'h0, max_out <= 4}, 32'h1);
        end

        // Single-pixel frame: eol and eof on the first pixel.
        for (int c = 0; c <= 4; c++) begin
            next_cycle();
            s_start = (c == 0);
            @(negedge clk);
            if (c == 1) chk("n1_busy", {31'h0, s_busy}, 32'h1);
            if (c == 3) chk("n1_pixel", {s_valid, s_data, s_x, s_y, s_eol, s_eof},
                            {1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1});
            if (c == 4) chk("n1_idle", {s_busy, s_valid}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
